// File: rtl/vader_pkg.sv
// Shared constants and state encoding for the dictionary loader and the cracking memory map.
package vader_pkg;
  localparam int DICT_START = 3;
  localparam int DICT_SIZE  = 4;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 128;

  // Header slots ahead of the dictionary entries.
  localparam int HPASS_ADDR = 0;
  localparam int KEY_ADDR   = 1;
  localparam int CHECK_ADDR = 2;

  typedef enum logic [1:0] {IDLE, PACK, WRITE, DONE} loader_state_t;
endpackage

// File: rtl/byte_packer_128.sv
// Packs bytes MSB-first into a 128-bit word; the register is cleared between words,
// so a word closed early by 'last' already carries zero low bytes.
module byte_packer_128 (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         accept,
  input  logic [7:0]   data,
  input  logic         last,
  output logic         word_full,
  output logic [127:0] word_out
);
  logic [3:0] idx;

  assign word_full = accept && (last || idx == 4'd15);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      word_out <= '0;
    end else if (clear) begin
      idx      <= '0;
      word_out <= '0;
    end else if (accept) begin
      // Byte k lands at bits [127-8k -: 8], i.e. top bit index {~k, 3'b111}.
      word_out[{~idx, 3'b111} -: 8] <= data;
      idx                           <= idx + 4'd1;
    end
  end
endmodule

// File: rtl/dict_loader.sv
// Streams bytes into 128-bit BRAM words at consecutive addresses from 0 (header, then dictionary).
// One WRITE cycle per word; in_ready drops during WRITE, so peak rate is 16 bytes per 17 cycles.
module dict_loader #(
  parameter int DICT_START = vader_pkg::DICT_START,
  parameter int DICT_SIZE  = vader_pkg::DICT_SIZE,
  parameter int ADDR_W     = vader_pkg::ADDR_W,
  parameter int DATA_W     = vader_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] word_count
);
  import vader_pkg::*;

  localparam int                CAP    = DICT_START + DICT_SIZE;
  localparam logic [ADDR_W-1:0] CAP_M1 = ADDR_W'(CAP - 1);
  localparam logic [ADDR_W-1:0] CAP_W  = ADDR_W'(CAP);

  loader_state_t state_q, state_d;
  logic          start_take;
  logic          beat;
  logic          pack_beat;
  logic          word_full;
  logic          last_seen;
  logic [127:0]  word;

  assign beat      = in_valid && in_ready;
  assign pack_beat = beat && (state_q == PACK);

  byte_packer_128 u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_take || (state_q == WRITE)),
    .accept    (pack_beat),
    .data      (in_data),
    .last      (in_last),
    .word_full (word_full),
    .word_out  (word)
  );

  always_comb begin
    state_d    = state_q;
    start_take = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = PACK;
          start_take = 1'b1;
        end
      end
      PACK:    if (word_full) state_d = WRITE;
      WRITE:   state_d = (last_seen || word_count == CAP_M1) ? DONE : PACK;
      default: state_d = IDLE;
    endcase
  end

  // A start arriving in DONE takes priority over a beat, so the beat is refused.
  assign in_ready = (state_q == PACK) || ((state_q == DONE) && !start);
  assign ena      = (state_q == WRITE);
  assign wea      = (state_q == WRITE);
  assign busy     = (state_q == PACK) || (state_q == WRITE);
  assign done     = (state_q == DONE);
  assign dina     = word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addra      <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      last_seen  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_take) begin
        addra      <= '0;
        word_count <= '0;
        overflow   <= 1'b0;
        last_seen  <= 1'b0;
      end else begin
        if (pack_beat && in_last) last_seen <= 1'b1;
        if (state_q == WRITE) begin
          if (addra != CAP_M1)     addra      <= addra + 1'b1;
          if (word_count != CAP_W) word_count <= word_count + 1'b1;
        end
        if ((state_q == DONE) && beat) overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dict_loader.sv
// Directed bench for dict_loader: a session-level model predicts every BRAM write and status value.
module tb_dict_loader;
  localparam int CAP = 7;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic         ena;
  logic         wea;
  logic [7:0]   addra;
  logic [127:0] dina;
  logic         busy;
  logic         done;
  logic         overflow;
  logic [7:0]   word_count;

  dict_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .ena        (ena),
    .wea        (wea),
    .addra      (addra),
    .dina       (dina),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           addr;
    logic [127:0] data;
    int           due;
  } wr_t;

  wr_t          exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  bit           mon_en = 1'b0;
  logic [7:0]   data_buf [0:127];
  logic [127:0] got_mem  [0:7];
  logic [127:0] s1_mem   [0:7];

  // Session model: bytes fill words MSB-first; a word closes on 16 bytes or last.
  bit           m_busy = 1'b0;
  bit           m_done = 1'b0;
  bit           m_ovf  = 1'b0;
  int           m_words = 0;
  int           m_k = 0;
  logic [127:0] m_word = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    m_busy = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
    m_words = 0; m_k = 0; m_word = '0;
  endfunction

  function automatic void model_start();
    if (!m_busy) begin
      model_clear();
      m_busy = 1'b1;
    end
  endfunction

  function automatic void model_push(input logic [7:0] b, input bit last);
    wr_t e;
    if (m_done) begin
      m_ovf = 1'b1;
    end else begin
      m_word[127 - 8*m_k -: 8] = b;
      m_k++;
      if (m_k == 16 || last) begin
        e.addr = m_words;
        e.data = m_word;
        e.due  = cyc + 1;
        exp_q.push_back(e);
        m_words++;
        m_k = 0;
        m_word = '0;
        if (last || m_words == CAP) begin
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    wr_t e;
    if (!reset && mon_en) begin
      chk("ena_eq_wea", 160'(ena), 160'(wea));
      chk("addra_max", 160'(addra > 8'(CAP - 1)), 160'(0));
      if (busy) chk("ready_vs_write", 160'(in_ready), 160'(!wea));
      if (wea) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addra=%0d dina=%0h with no write expected", addra, dina);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", 160'(addra), 160'(e.addr));
          chk("write_data", 160'(dina), 160'(e.data));
          chk("write_latency", 160'(cyc), 160'(e.due));
        end
        if (addra < 8) got_mem[addra[2:0]] = dina;
      end
    end
  end

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    model_start();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    int t = 0;
    in_data = b; in_valid = 1'b1; in_last = last;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end else begin
      model_push(b, last);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
  endtask

  task automatic run_stream(input int n, input bit last_end, input bit gaps, input int start_at);
    for (int i = 0; i < n; i++) begin
      if (i == start_at) do_start();
      if (gaps && $urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
      send_byte(data_buf[i], last_end && (i == n - 1));
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 100) begin
      t++;
      @(negedge clk);
    end
    chk("done_reached", 160'(done), 160'(1));
    repeat (2) @(negedge clk);
  endtask

  task automatic session_checks();
    chk("queue_drained", 160'(exp_q.size()), 160'(0));
    chk("word_count", 160'(word_count), 160'(m_words));
    chk("overflow", 160'(overflow), 160'(m_ovf));
    chk("addra_final", 160'(addra), 160'((m_words < CAP) ? m_words : CAP - 1));
    chk("busy_idle", 160'(busy), 160'(0));
  endtask

  function automatic void fill_s1();
    string s = "Discombobulateme";
    for (int i = 0; i < 128; i++)
      data_buf[i] = (i < 16) ? s[i] : 8'((i * 37 + 11) & 255);
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    for (int i = 0; i < 8; i++) got_mem[i] = '0;
    fill_s1();
    #1;
    chk("reset_outputs", 160'({in_ready, ena, wea, addra, dina, busy, done, overflow, word_count}), 160'(0));
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;

    // 1: full load of 112 bytes, no last.
    do_start();
    run_stream(112, 1'b0, 1'b0, -1);
    wait_done();
    session_checks();
    chk("s1_word_count", 160'(word_count), 160'(7));
    chk("s1_overflow", 160'(overflow), 160'(0));
    chk("s1_word0", 160'(got_mem[0]), 160'(128'h446973636F6D626F62756C6174656D65));
    for (int a = 0; a < 8; a++) s1_mem[a] = got_mem[a];

    // 2: short session "abc" closed by last.
    data_buf[0] = 8'h61; data_buf[1] = 8'h62; data_buf[2] = 8'h63;
    do_start();
    run_stream(3, 1'b1, 1'b0, -1);
    wait_done();
    session_checks();
    chk("s2_word0", 160'(got_mem[0]), 160'(128'h61626300000000000000000000000000));
    chk("s2_word_count", 160'(word_count), 160'(1));
    chk("s2_addra", 160'(addra), 160'(1));

    // last on byte 15 gives exactly one write.
    fill_s1();
    do_start();
    run_stream(16, 1'b1, 1'b0, -1);
    wait_done();
    session_checks();
    chk("last15_word_count", 160'(word_count), 160'(1));

    // 3: full load, two extra bytes, then start colliding with a beat in DONE.
    do_start();
    run_stream(112, 1'b0, 1'b0, -1);
    wait_done();
    send_byte(8'hEE, 1'b0);
    send_byte(8'hEF, 1'b0);
    repeat (2) @(negedge clk);
    session_checks();
    chk("s3_overflow", 160'(overflow), 160'(1));
    chk("s3_word_count_sat", 160'(word_count), 160'(7));
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    @(negedge clk);
    chk("start_wins_ready", 160'(in_ready), 160'(0));
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; in_data = '0;
    model_start();
    chk("s3_overflow_cleared", 160'(overflow), 160'(0));
    chk("s3_done_cleared", 160'(done), 160'(0));
    chk("s3_busy", 160'(busy), 160'(1));
    send_byte(8'h5A, 1'b1);
    wait_done();
    session_checks();
    chk("s3_restart_word0", 160'(got_mem[0]), 160'(128'h5A000000000000000000000000000000));

    // 4: random valid gaps, same contents as scenario 1.
    do_start();
    run_stream(112, 1'b0, 1'b1, -1);
    wait_done();
    session_checks();
    for (int a = 0; a < CAP; a++) chk("s4_same_as_s1", 160'(got_mem[a]), 160'(s1_mem[a]));

    // 6: start pulsed mid-word is ignored.
    do_start();
    run_stream(112, 1'b0, 1'b0, 20);
    wait_done();
    session_checks();
    chk("s6_word_count", 160'(word_count), 160'(7));

    // 5: reset after 9 bytes of word 3.
    for (int i = 0; i < 8; i++) got_mem[i] = '0;
    do_start();
    run_stream(57, 1'b0, 1'b0, -1);
    repeat (2) @(negedge clk);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("s5_async_reset", 160'({in_ready, ena, wea, addra, dina, busy, done, overflow, word_count}), 160'(0));
    chk("s5_queue", 160'(exp_q.size()), 160'(0));
    chk("s5_no_addr3", 160'(got_mem[3]), 160'(0));
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0;
    do_start();
    run_stream(16, 1'b1, 1'b0, -1);
    wait_done();
    session_checks();
    chk("s5_rewrite_word0", 160'(got_mem[0]), 160'(128'h446973636F6D626F62756C6174656D65));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dict_loader.md
Name: dict_loader

Overview:
- BRAM writer that fills the SD-card simulation memory the cracking controller reads from.
- Accepts a byte stream over a valid/ready handshake and packs 16 bytes MSB-first into 128-bit words.
- Writes the words to consecutive addresses from 0: header slots (hashed password, key, check ciphertext), then dictionary entries from DICT_START.
- Sits between a host/UART byte source and the BRAM write port.

Parameters:
- DICT_START, 3, first dictionary address; addresses 0..DICT_START-1 are header words.
- DICT_SIZE, 4, number of dictionary entries.
- ADDR_W, 8, BRAM address width.
- DATA_W, 128, BRAM word width; fixed at 16 bytes.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load session.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- in_last  in  1  qualifies the final byte of the session.
- ena  out  1  BRAM enable.
- wea  out  1  BRAM write enable.
- addra  out  ADDR_W  BRAM address.
- dina  out  DATA_W  BRAM write data.
- busy  out  1  session in progress.
- done  out  1  session complete; sticky.
- overflow  out  1  bytes arrived beyond capacity; sticky.
- word_count  out  ADDR_W  words written this session.

Behaviour:
- Reset (asynchronous, active-high). Every output goes to 0: in_ready, ena, wea, addra, dina, busy, done, overflow, word_count. State goes to IDLE and the byte index to 0. Reset mid-word discards the partial word; no write is issued.
- Capacity: CAP = DICT_START + DICT_SIZE words (default 7).

States:
- IDLE:
  - in_ready = 0.
  - start moves to PACK and clears addra, word_count, done, overflow and the byte index.
- PACK:
  - in_ready = 1 and busy = 1.
  - Each accepted beat (in_valid && in_ready) stores byte k into dina[127-8k -: 8], k = 0..15.
  - Go to WRITE when byte 15 is accepted, or when in_last is accepted with any k. In the in_last case the unfilled low bytes are 0x00.
- WRITE (exactly one cycle):
  - ena = 1, wea = 1, addra = current address, dina = the packed word; in_ready = 0.
  - Next cycle: word_count += 1, addra += 1, byte index = 0, and the packing register is cleared.
  - Go to DONE if in_last was seen or word_count + 1 == CAP; otherwise return to PACK.
- DONE:
  - done = 1, busy = 0, in_ready = 1 (the stream is drained).
  - Any accepted beat sets overflow. No further writes are issued.
  - start restarts the session as described for IDLE.

Timing and rules:
- ena and wea are 0 in every state except WRITE. No BRAM reads are issued.
- Latency: a word-completing byte accepted in cycle N gives wea = 1 in N+1 and in_ready = 1 again in N+2. Peak throughput is 16 bytes per 17 cycles.
- start while busy is ignored.
- start and a beat in the same cycle in DONE: start wins; the beat is not accepted (in_ready is deasserted that cycle) and overflow is not set.
- in_last on byte 15 produces one write only, with no extra zero word.
- addra never exceeds CAP-1. word_count saturates at CAP.
- Exactly 16*CAP bytes without in_last: DONE is entered after the CAP-th write; overflow stays 0 unless more bytes arrive.

Decomposition:
- Shared package vader_pkg: DICT_START, DICT_SIZE, ADDR_W, DATA_W, the loader state enum (IDLE, PACK, WRITE, DONE), and header slot constants HPASS_ADDR = 0, KEY_ADDR = 1, CHECK_ADDR = 2.
- One sub-module, byte_packer_128: byte index counter, MSB-first shift/insert, zero-fill on last, word_full/word_out outputs. dict_loader keeps the FSM, address and count.

Test Plan:
1. Reset, start, stream 112 bytes (7 × 16, "Discombobulateme" as word 0), no in_last -> seven single-cycle wea pulses at addra 0..6; dina at addr 0 = 0x446973636F6D626F62756C6174656D65; done = 1, word_count = 7, overflow = 0.
2. Start, stream "abc" with in_last on 'c' -> one write at addra 0, dina = 0x616263 followed by 13 zero bytes; done = 1, word_count = 1.
3. Full load, then 2 extra bytes -> both accepted, overflow = 1, no wea; start clears overflow/done and the next write lands at addra 0.
4. in_valid toggled randomly 50% -> same BRAM contents as scenario 1; in_ready = 0 exactly in WRITE cycles.
5. Assert reset after 9 bytes of word 3 -> all outputs 0 immediately (asynchronous), no write to addr 3; a new start rewrites from addra 0.
6. start pulsed mid-session during PACK -> ignored; addra/word_count sequence unchanged.
